// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs PACK entries of a first-word-fall-through FIFO into one output word
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_empty_i,
  input  logic [DATA_W-1:0]          fifo_data_i,
  output logic                       fifo_pop_o,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PACK*DATA_W-1:0]     out_data_o,
  output logic [$clog2(PACK+1)-1:0]  out_count_o
);

  localparam int IDX_W = $clog2(PACK);
  localparam int CNT_W = $clog2(PACK+1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PACK*DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    count_d    = count_q;
    valid_d    = valid_q;
    fifo_pop_o = (state_q == FILL) && !fifo_empty_i && !reset;

    case (state_q)
      FILL: begin
        if (fifo_pop_o) begin
          for (int i = 0; i < PACK; i++) begin
            if (idx_q == IDX_W'(i)) begin
              data_d[i*DATA_W +: DATA_W] = fifo_data_i;
            end
          end
          // A flush in the same cycle as a pop still includes the popped entry
          if (idx_q == IDX_W'(PACK-1) || flush_i) begin
            state_d = HOLD;
            valid_d = 1'b1;
            count_d = CNT_W'(idx_q) + CNT_W'(1);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (flush_i && idx_q != '0) begin
          state_d = HOLD;
          valid_d = 1'b1;
          count_d = CNT_W'(idx_q);
          idx_d   = '0;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = FILL;
          valid_d = 1'b0;
          count_d = '0;
          data_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_count_o = count_q;

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the FIFO entry width in bits.
REQ-002 The block SHALL have parameter PACK, default 4, giving the number of FIFO entries per output word (PACK >= 2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port fifo_empty_i  input  1  empty flag from the upstream synchronous FIFO.
REQ-006 The block SHALL have port fifo_data_i  input  DATA_W  FIFO head entry, valid whenever fifo_empty_i=0 (first-word-fall-through).
REQ-007 The block SHALL have port fifo_pop_o  output  1  pop strobe to the FIFO, one entry consumed per cycle asserted.
REQ-008 The block SHALL have port flush_i  input  1  request to emit a partially filled word.
REQ-009 The block SHALL have port out_valid_o  output  1  packed word available.
REQ-010 The block SHALL have port out_ready_i  input  1  downstream accepts the word when out_valid_o=1.
REQ-011 The block SHALL have port out_data_o  output  PACK*DATA_W  packed word.
REQ-012 The block SHALL have port out_count_o  output  $clog2(PACK+1)  number of valid lanes in out_data_o (1..PACK).

Function
REQ-013 The block SHALL implement a two-state FSM: FILL (collecting entries) and HOLD (presenting a word).
REQ-014 fifo_pop_o SHALL equal (state==FILL) && !fifo_empty_i && !reset, combinationally; it SHALL never be asserted while fifo_empty_i=1.
REQ-015 In FILL, each pop SHALL write fifo_data_i into lane idx (bits idx*DATA_W +: DATA_W) and increment lane index idx; lane 0 is the first entry popped (LSBs).
REQ-016 A pop with idx==PACK-1 SHALL transition FILL->HOLD with out_count_o=PACK; out_valid_o SHALL rise the cycle after that pop (1-cycle latency).
REQ-017 flush_i in FILL with no pop that cycle and idx>0 SHALL transition to HOLD with out_count_o=idx.
REQ-018 flush_i with a pop in the same cycle SHALL include the popped entry and transition to HOLD with out_count_o=idx+1.
REQ-019 flush_i with idx==0 and no pop SHALL be ignored; flush_i in HOLD SHALL be ignored.
REQ-020 Lanes at or above out_count_o SHALL read as zero.
REQ-021 In HOLD, out_valid_o SHALL be 1, and out_data_o/out_count_o SHALL remain stable until out_ready_i=1.
REQ-022 In HOLD with out_ready_i=1, the FSM SHALL return to FILL next cycle with idx=0, all lanes cleared, out_valid_o=0, out_count_o=0.
REQ-023 No pop SHALL occur in HOLD; steady-state throughput is one word per PACK+1 cycles.
REQ-024 out_valid_o, out_data_o and out_count_o SHALL be driven from registers.

Reset
REQ-025 With reset=1 at a rising edge, the block SHALL enter FILL with idx=0, out_valid_o=0, out_data_o=0, out_count_o=0, regardless of current state.
REQ-026 While reset=1, fifo_pop_o SHALL be 0; a partially filled or held word SHALL be discarded, not emitted.

Verification (DATA_W=8, PACK=4)
REQ-027 FIFO holds 0x11,0x22,0x33,0x44, out_ready_i=1 -> four consecutive pops, then out_valid_o=1 with out_data_o=0x44332211, out_count_o=4 for one cycle.
REQ-028 Full word held with out_ready_i=0 for 5 cycles while FIFO non-empty -> out_valid_o stays 1, out_data_o stable, fifo_pop_o=0 throughout; accept on cycle 6, pops resume next cycle.
REQ-029 Pop 0xAA,0xBB, FIFO empty, pulse flush_i -> out_data_o=0x0000BBAA, out_count_o=2.
REQ-030 Pops 0x01,0x02,0x03 with flush_i asserted in the cycle of the 3rd pop -> out_data_o=0x00030201, out_count_o=3, 4th entry remains in FIFO.
REQ-031 flush_i pulsed with idx=0 and FIFO empty -> out_valid_o stays 0, no pop.
REQ-032 reset asserted in HOLD and after 2 pops in FILL -> next cycle out_valid_o=0, out_data_o=0, out_count_o=0, fifo_pop_o=0 during reset; next word starts at lane 0.
